// File: rtl/pulse_stretch_gen.sv
// Stretches single-cycle event strobes into clean output pulses with a guaranteed
// high time and low guard time; strobes arriving mid-pulse are queued and replayed.
module pulse_stretch_gen #(
  parameter int unsigned HIGH_CYCLES = 130000,
  parameter int unsigned GAP_CYCLES  = 130000,
  parameter int unsigned CNT_W       = 17,
  parameter int unsigned PEND_W      = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              trig_i,
  output logic              dout_o,
  output logic              busy_o,
  output logic [PEND_W-1:0] pend_o,
  output logic              overflow_o
);

  typedef enum logic [1:0] {StIdle, StHigh, StGap} state_e;

  localparam logic [CNT_W-1:0]  HighLast = CNT_W'(HIGH_CYCLES - 1);
  localparam logic [CNT_W-1:0]  GapLast  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [PEND_W-1:0] PendMax  = '1;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   timer_q, timer_d;
  logic [PEND_W-1:0]  pend_q, pend_d;
  logic               dout_q, dout_d;
  logic               busy_q, busy_d;
  logic               ovf_q, ovf_d;
  logic               launch, pend_nz, consume_pend, enq;

  always_comb begin
    state_d      = state_q;
    timer_d      = '0;
    pend_d       = pend_q;
    ovf_d        = 1'b0;
    launch       = 1'b0;
    pend_nz      = (pend_q != '0);

    case (state_q)
      StIdle: begin
        if (trig_i || pend_nz) begin
          state_d = StHigh;
          launch  = 1'b1;
        end
      end
      StHigh: begin
        if (timer_q == HighLast) begin
          state_d = StGap;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      StGap: begin
        // Relaunch straight from the last gap cycle so the low time stays exact.
        if (timer_q == GapLast) begin
          if (trig_i || pend_nz) begin
            state_d = StHigh;
            launch  = 1'b1;
          end else begin
            state_d = StIdle;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    // Queued requests are served before the current strobe.
    consume_pend = launch && pend_nz;
    enq          = trig_i && !(launch && !pend_nz);

    if (enq && !consume_pend) begin
      if (pend_q == PendMax) begin
        ovf_d = 1'b1;
      end else begin
        pend_d = pend_q + 1'b1;
      end
    end else if (!enq && consume_pend) begin
      pend_d = pend_q - 1'b1;
    end

    dout_d = (state_d == StHigh);
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      timer_q <= '0;
      pend_q  <= '0;
      dout_q  <= 1'b0;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      pend_q  <= pend_d;
      dout_q  <= dout_d;
      busy_q  <= busy_d;
      ovf_q   <= ovf_d;
    end
  end

  assign dout_o     = dout_q;
  assign busy_o     = busy_q;
  assign pend_o     = pend_q;
  assign overflow_o = ovf_q;

endmodule

// File: tb/tb_pulse_stretch_gen.sv
// Bench for pulse_stretch_gen: per-cycle vectors with hand-derived expected outputs,
// routed through an expected-value queue and compared one cycle after each edge.
module tb_pulse_stretch_gen;

  localparam int unsigned HighCycles = 4;
  localparam int unsigned GapCycles  = 3;
  localparam int unsigned CntW       = 2;
  localparam int unsigned PendW      = 2;

  typedef struct packed {
    logic             rst;
    logic             trig;
    logic             dout;
    logic             busy;
    logic [PendW-1:0] pend;
    logic             ovf;
  } vec_t;

  logic             clk;
  logic             rst;
  logic             trig;
  logic             dout;
  logic             busy;
  logic [PendW-1:0] pend;
  logic             overflow;

  vec_t vecs[$];
  vec_t exp_q[$];
  int   checks;
  int   errors;
  int   cyc;

  pulse_stretch_gen #(
    .HIGH_CYCLES(HighCycles),
    .GAP_CYCLES (GapCycles),
    .CNT_W      (CntW),
    .PEND_W     (PendW)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .trig_i    (trig),
    .dout_o    (dout),
    .busy_o    (busy),
    .pend_o    (pend),
    .overflow_o(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add(input logic r, input logic t, input logic d, input logic b,
                     input int p, input logic o, input int n);
    vec_t v;
    v.rst  = r;
    v.trig = t;
    v.dout = d;
    v.busy = b;
    v.pend = PendW'(p);
    v.ovf  = o;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endtask

  task automatic compare(input string name, input vec_t e);
    checks++;
    if (dout !== e.dout || busy !== e.busy || pend !== e.pend || overflow !== e.ovf) begin
      errors++;
      $display("FAIL %s cyc %0d: got dout=%b busy=%b pend=%0d ovf=%b, want dout=%b busy=%b pend=%0d ovf=%b",
               name, cyc, dout, busy, pend, overflow, e.dout, e.busy, e.pend, e.ovf);
    end
  endtask

  task automatic run_vecs(input string name);
    vec_t v;
    vec_t e;
    cyc = 0;
    while (vecs.size() > 0) begin
      v = vecs.pop_front();
      @(negedge clk);
      rst  = v.rst;
      trig = v.trig;
      exp_q.push_back(v);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      compare(name, e);
      cyc++;
    end
  endtask

  initial begin
    vec_t e;
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    trig   = 1'b0;

    // Reset and idle hold
    add(1, 0, 0, 0, 0, 0, 2);
    add(0, 0, 0, 0, 0, 0, 3);
    run_vecs("reset");

    // Single trig: 4 high, 3 low, then idle
    add(0, 1, 1, 1, 0, 0, 1);
    add(0, 0, 1, 1, 0, 0, 3);
    add(0, 0, 0, 1, 0, 0, 3);
    add(0, 0, 0, 0, 0, 0, 2);
    run_vecs("single");

    // Launch plus 4 trigs during HIGH: pend 1,2,3 then overflow on the 4th
    add(0, 1, 1, 1, 0, 0, 1);
    add(0, 1, 1, 1, 1, 0, 1);
    add(0, 1, 1, 1, 2, 0, 1);
    add(0, 1, 1, 1, 3, 0, 1);
    add(0, 1, 0, 1, 3, 1, 1);
    add(0, 0, 0, 1, 3, 0, 2);
    for (int p = 2; p >= 0; p--) begin
      add(0, 0, 1, 1, p, 0, 4);
      add(0, 0, 0, 1, p, 0, 3);
    end
    add(0, 0, 0, 0, 0, 0, 2);
    run_vecs("queue");

    // Trig only on the last gap cycle relaunches with no idle cycle
    add(0, 1, 1, 1, 0, 0, 1);
    add(0, 0, 1, 1, 0, 0, 3);
    add(0, 0, 0, 1, 0, 0, 3);
    add(0, 1, 1, 1, 0, 0, 1);
    add(0, 0, 1, 1, 0, 0, 3);
    add(0, 0, 0, 1, 0, 0, 3);
    add(0, 0, 0, 0, 0, 0, 2);
    run_vecs("gap_trig");

    // Trig coinciding with a pend consume at gap end keeps pend at 1
    add(0, 1, 1, 1, 0, 0, 1);
    add(0, 1, 1, 1, 1, 0, 1);
    add(0, 0, 1, 1, 1, 0, 2);
    add(0, 0, 0, 1, 1, 0, 3);
    add(0, 1, 1, 1, 1, 0, 1);
    add(0, 0, 1, 1, 1, 0, 3);
    add(0, 0, 0, 1, 1, 0, 3);
    add(0, 0, 1, 1, 0, 0, 4);
    add(0, 0, 0, 1, 0, 0, 3);
    add(0, 0, 0, 0, 0, 0, 2);
    run_vecs("enq_consume");

    // Build pend=2 mid-HIGH, then reset asynchronously
    add(0, 1, 1, 1, 0, 0, 1);
    add(0, 1, 1, 1, 1, 0, 1);
    add(0, 1, 1, 1, 2, 0, 1);
    run_vecs("pre_reset");

    @(negedge clk);
    trig = 1'b0;
    rst  = 1'b1;
    #1;
    e = '0;
    cyc = 0;
    compare("async_reset", e);

    add(1, 0, 0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 12);
    run_vecs("post_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
